dlx_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage DLX core. It consumes the ID/EX pipeline-register outputs and the IF/ID instruction fields, and produces the enable, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three conditions:
- load-use hazards, with a configurable stall length;
- taken branches resolved in MEM;
- multi-cycle data-memory waits.

It also keeps saturating event counters for debug.

---
 rtl/dlx_pkg.sv | 17 +
 rtl/dlx_hazard_ctrl_if.sv | 52 +++++
 rtl/sat_counter.sv | 26 ++
 rtl/dlx_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_dlx_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX hazard-control slice.
// No logic; compile-time definitions only.
// Not applicable: no handshake lives here.
package dlx_pkg;

  // Architectural register-index width and the hard-wired zero register.
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Hazard controller states. HOLD remembers where to resume via ret_state.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/dlx_hazard_ctrl_if.sv
// Bundle of pipeline fields into, and control/debug outputs out of, the hazard controller.
// Pure wiring, zero latency.
// No backpressure: the controller itself is the pipeline's backpressure source.
interface dlx_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import dlx_pkg::*;

  // Pipeline fields observed by the controller
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             ifid_uses_rs2;
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_rt;
  logic             exmem_branch;
  logic             exmem_zero;
  logic             mem_busy;

  // Pipeline register controls
  logic             pc_write;
  logic             ifid_write;
  logic             pipe_en;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pc_sel_branch;

  // Debug event counters
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] hold_cnt;

  // Pipeline side: drives the fields, consumes the controls
  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_mem_read, idex_rt,
           exmem_branch, exmem_zero, mem_busy,
    input  pc_write, ifid_write, pipe_en, idex_bubble, ifid_flush,
           idex_flush, exmem_flush, pc_sel_branch,
           stall_cnt, flush_cnt, hold_cnt
  );

  // Hazard controller side
  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_mem_read, idex_rt,
           exmem_branch, exmem_zero, mem_busy,
    output pc_write, ifid_write, pipe_en, idex_bubble, ifid_flush,
           idex_flush, exmem_flush, pc_sel_branch,
           stall_cnt, flush_cnt, hold_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for debug event statistics.
// Count visible one cycle after inc; clr is synchronous and wins over inc.
// No backpressure: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Clear, or count up until all-ones and hold there
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/dlx_hazard_ctrl.sv
// DLX hazard controller: load-use stalls, MEM-resolved branch flushes, data-memory freezes.
// Controls are combinational (same cycle); state and counters update on the next edge.
// mem_busy freezes everything (HOLD) and resumes the interrupted RUN/STALL with remain intact.
module dlx_hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  dlx_hazard_ctrl_if.slave bus
);
  import dlx_pkg::*;

  // Remain value loaded on the first stall cycle: the cycles still owed after this one.
  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

  state_t     r_state;
  state_t     r_ret_state;
  logic [2:0] r_remain;

  state_t     w_nxt_state;
  state_t     w_nxt_ret;
  logic [2:0] w_nxt_remain;
  state_t     w_eff_state;
  logic       w_lu;
  logic       w_tk;
  logic       w_stall_inc;
  logic       w_flush_inc;
  logic       w_hold_inc;

  logic w_pc_write, w_ifid_write, w_pipe_en, w_idex_bubble;
  logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_pc_sel_branch;

  assign w_lu = bus.idex_mem_read && (bus.idex_rt != REG_ZERO) &&
                ((bus.idex_rt == bus.ifid_rs1) ||
                 (bus.ifid_uses_rs2 && (bus.idex_rt == bus.ifid_rs2)));
  assign w_tk = bus.exmem_branch && bus.exmem_zero;

  // Leaving HOLD behaves exactly like the state that was interrupted.
  assign w_eff_state = (r_state == ST_HOLD) ? r_ret_state : r_state;

  // Next-state and control outputs, priority reset > mem_busy > taken branch > load-use/STALL
  always_comb begin
    w_pc_write      = 1'b1;
    w_ifid_write    = 1'b1;
    w_pipe_en       = 1'b1;
    w_idex_bubble   = 1'b0;
    w_ifid_flush    = 1'b0;
    w_idex_flush    = 1'b0;
    w_exmem_flush   = 1'b0;
    w_pc_sel_branch = 1'b0;
    w_nxt_state     = r_state;
    w_nxt_ret       = r_ret_state;
    w_nxt_remain    = r_remain;
    w_stall_inc     = 1'b0;
    w_flush_inc     = 1'b0;
    w_hold_inc      = 1'b0;

    if (reset) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_pipe_en     = 1'b0;
      w_idex_bubble = 1'b1;
    end else if (bus.mem_busy) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_pipe_en    = 1'b0;
      // Capture the resume point only when first entering HOLD.
      if (r_state != ST_HOLD) begin
        w_nxt_ret = (r_state == ST_RUN) ? ST_RUN : ST_STALL;
      end
      w_nxt_state = ST_HOLD;
      w_hold_inc  = 1'b1;
    end else if (w_tk) begin
      // Branch flush also cancels any pending load stall; flush beats bubble.
      w_pc_sel_branch = 1'b1;
      w_ifid_flush    = 1'b1;
      w_idex_flush    = 1'b1;
      w_exmem_flush   = 1'b1;
      w_nxt_state     = ST_RUN;
      w_nxt_remain    = '0;
      w_flush_inc     = 1'b1;
    end else if (w_eff_state == ST_STALL) begin
      // lu is not re-checked here: ID/EX already carries a bubble.
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_stall_inc   = 1'b1;
      w_nxt_remain  = r_remain - 3'd1;
      w_nxt_state   = (r_remain == 3'd1) ? ST_RUN : ST_STALL;
    end else begin
      w_nxt_state = ST_RUN;
      if (w_lu) begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
        w_stall_inc   = 1'b1;
        if (LOAD_STALL > 1) begin
          w_nxt_state  = ST_STALL;
          w_nxt_remain = STALL_INIT;
        end
      end
    end
  end

  // State register; reset overrides any in-flight STALL or HOLD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_remain    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_ret_state <= w_nxt_ret;
      r_remain    <= w_nxt_remain;
    end
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.ifid_write    = w_ifid_write;
  assign bus.pipe_en       = w_pipe_en;
  assign bus.idex_bubble   = w_idex_bubble;
  assign bus.ifid_flush    = w_ifid_flush;
  assign bus.idex_flush    = w_idex_flush;
  assign bus.exmem_flush   = w_exmem_flush;
  assign bus.pc_sel_branch = w_pc_sel_branch;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (w_stall_inc),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (w_flush_inc),
    .cnt (bus.flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .clr (reset),
    .inc (w_hold_inc),
    .cnt (bus.hold_cnt)
  );

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Bench for dlx_hazard_ctrl: two instances (LOAD_STALL=1/CNT_W=32 and LOAD_STALL=3/CNT_W=3)
// share one stimulus; a cycle-level reference model checks both every cycle.
// Directed table, hand-written multi-cycle sequences, then randomized traffic.
module tb_dlx_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] s_rs1, s_rs2, s_rt;
  logic       s_u2, s_mr, s_br, s_zero, s_busy;

  dlx_hazard_ctrl_if #(.CNT_W(32)) ifa ();
  dlx_hazard_ctrl_if #(.CNT_W(3))  ifb ();

  assign ifa.ifid_rs1      = s_rs1;
  assign ifa.ifid_rs2      = s_rs2;
  assign ifa.ifid_uses_rs2 = s_u2;
  assign ifa.idex_mem_read = s_mr;
  assign ifa.idex_rt       = s_rt;
  assign ifa.exmem_branch  = s_br;
  assign ifa.exmem_zero    = s_zero;
  assign ifa.mem_busy      = s_busy;
  assign ifb.ifid_rs1      = s_rs1;
  assign ifb.ifid_rs2      = s_rs2;
  assign ifb.ifid_uses_rs2 = s_u2;
  assign ifb.idex_mem_read = s_mr;
  assign ifb.idex_rt       = s_rt;
  assign ifb.exmem_branch  = s_br;
  assign ifb.exmem_zero    = s_zero;
  assign ifb.mem_busy      = s_busy;

  dlx_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  dlx_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(3))  dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  // {pc_write, ifid_write, pipe_en, idex_bubble, ifid_flush, idex_flush, exmem_flush, pc_sel_branch}
  wire [7:0] a_out = {ifa.pc_write, ifa.ifid_write, ifa.pipe_en, ifa.idex_bubble,
                      ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush, ifa.pc_sel_branch};
  wire [7:0] b_out = {ifb.pc_write, ifb.ifid_write, ifb.pipe_en, ifb.idex_bubble,
                      ifb.ifid_flush, ifb.idex_flush, ifb.exmem_flush, ifb.pc_sel_branch};

  localparam logic [7:0] O_RST   = 8'b0001_0000;
  localparam logic [7:0] O_FRZ   = 8'b0000_0000;
  localparam logic [7:0] O_FLUSH = 8'b1110_1111;
  localparam logic [7:0] O_STALL = 8'b0011_0000;
  localparam logic [7:0] O_RUN   = 8'b1110_0000;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each DUT owes m_left further stall cycles; counters saturate at m_max.
  int     m_left [2];
  longint m_cnt  [2][3];   // stall, flush, hold
  int     m_ls   [2] = '{1, 3};
  longint m_max  [2] = '{64'hFFFF_FFFF, 64'd7};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic lu_now();
    return s_mr && (s_rt != 5'd0) && ((s_rt == s_rs1) || (s_u2 && (s_rt == s_rs2)));
  endfunction

  function automatic logic [7:0] model_out(input int k);
    if (reset)                   return O_RST;
    if (s_busy)                  return O_FRZ;
    if (s_br && s_zero)          return O_FLUSH;
    if (m_left[k] > 0 || lu_now()) return O_STALL;
    return O_RUN;
  endfunction

  task automatic bump(input int k, input int c);
    if (m_cnt[k][c] < m_max[k]) m_cnt[k][c] = m_cnt[k][c] + 1;
  endtask

  task automatic model_advance(input int k);
    if (reset) begin
      m_left[k] = 0;
      for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
    end else if (s_busy) begin
      bump(k, 2);
    end else if (s_br && s_zero) begin
      m_left[k] = 0;
      bump(k, 1);
    end else if (m_left[k] > 0) begin
      m_left[k] = m_left[k] - 1;
      bump(k, 0);
    end else if (lu_now()) begin
      m_left[k] = m_ls[k] - 1;
      bump(k, 0);
    end
  endtask

  // Check both DUTs against the model at the falling edge, advance the model, cross the rising edge.
  task automatic step();
    @(negedge clk);
    chk("a_stall_cnt", 64'(ifa.stall_cnt), m_cnt[0][0]);
    chk("a_flush_cnt", 64'(ifa.flush_cnt), m_cnt[0][1]);
    chk("a_hold_cnt",  64'(ifa.hold_cnt),  m_cnt[0][2]);
    chk("b_stall_cnt", 64'(ifb.stall_cnt), m_cnt[1][0]);
    chk("b_flush_cnt", 64'(ifb.flush_cnt), m_cnt[1][1]);
    chk("b_hold_cnt",  64'(ifb.hold_cnt),  m_cnt[1][2]);
    chk("a_ctrl", 64'(a_out), 64'(model_out(0)));
    chk("b_ctrl", 64'(b_out), 64'(model_out(1)));
    model_advance(0);
    model_advance(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_rs1 = 5'd1; s_rs2 = 5'd2; s_rt = 5'd0; s_u2 = 1'b0;
    s_mr = 1'b0; s_br = 1'b0; s_zero = 1'b0; s_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_lu_rs2();
    s_mr = 1'b1; s_rt = 5'd7; s_rs2 = 5'd7; s_u2 = 1'b1; s_rs1 = 5'd3;
  endtask

  typedef struct {
    logic       mr;
    logic [4:0] rt, rs1, rs2;
    logic       u2, br, zero, busy;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // Single-cycle controls for dut_a, each applied from RUN.
    tbl[0] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[1] = '{1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_STALL};
    tbl[2] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL};
    tbl[3] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[4] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[5] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, O_FLUSH};
    tbl[6] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN};
    tbl[7] = '{1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, O_FLUSH};
    tbl[8] = '{1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, O_FRZ};
    tbl[9] = '{1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, O_FRZ};

    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0;
      for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
    end

    // Bring state out of X before any checking.
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Outputs while reset is held, then counters after the edge.
    chk("rst_ctrl_a", 64'(a_out), 64'(O_RST));
    chk("rst_ctrl_b", 64'(b_out), 64'(O_RST));
    step();
    reset = 1'b0;
    #1;
    chk("rst_stall_a", 64'(ifa.stall_cnt), 64'd0);
    chk("rst_run_a", 64'(a_out), 64'(O_RUN));

    // Table-driven single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      do_reset();
      s_mr = tbl[i].mr; s_rt = tbl[i].rt; s_rs1 = tbl[i].rs1; s_rs2 = tbl[i].rs2;
      s_u2 = tbl[i].u2; s_br = tbl[i].br; s_zero = tbl[i].zero; s_busy = tbl[i].busy;
      #1;
      chk($sformatf("tbl%0d", i), 64'(a_out), 64'(tbl[i].exp));
      step();
      idle();
      step();
    end

    // Load-use through rs2: one stall cycle on dut_a, three on dut_b
    do_reset();
    set_lu_rs2();
    #1;
    chk("lu_c1_a", 64'(a_out), 64'(O_STALL));
    chk("lu_c1_b", 64'(b_out), 64'(O_STALL));
    step();
    s_mr = 1'b0;   // the bubble now sits in ID/EX
    #1;
    chk("lu_done_a", 64'(a_out), 64'(O_RUN));
    chk("lu_cnt_a", 64'(ifa.stall_cnt), 64'd1);
    chk("lu_c2_b", 64'(b_out), 64'(O_STALL));
    step();
    #1;
    chk("lu_c3_b", 64'(b_out), 64'(O_STALL));
    step();
    #1;
    chk("lu_done_b", 64'(b_out), 64'(O_RUN));
    chk("lu_cnt_b", 64'(ifb.stall_cnt), 64'd3);
    step();

    // Taken branch, then not-taken
    do_reset();
    s_br = 1'b1; s_zero = 1'b1;
    #1;
    chk("tk_a", 64'(a_out), 64'(O_FLUSH));
    step();
    s_zero = 1'b0;
    #1;
    chk("nt_a", 64'(a_out), 64'(O_RUN));
    chk("tk_cnt_a", 64'(ifa.flush_cnt), 64'd1);
    step();
    #1;
    chk("nt_cnt_a", 64'(ifa.flush_cnt), 64'd1);

    // Branch on the last owed stall cycle of dut_b
    do_reset();
    set_lu_rs2();
    step();
    s_mr = 1'b0;
    step();
    s_br = 1'b1; s_zero = 1'b1;
    #1;
    chk("tk_stall_b", 64'(b_out), 64'(O_FLUSH));
    step();
    idle();
    #1;
    chk("tk_after_b", 64'(b_out), 64'(O_RUN));
    chk("tk_stallcnt_b", 64'(ifb.stall_cnt), 64'd2);
    chk("tk_flushcnt_b", 64'(ifb.flush_cnt), 64'd1);
    step();

    // Branch with two stall cycles still owed aborts them
    do_reset();
    set_lu_rs2();
    step();
    s_mr = 1'b0; s_br = 1'b1; s_zero = 1'b1;
    #1;
    chk("abort_tk_b", 64'(b_out), 64'(O_FLUSH));
    step();
    idle();
    #1;
    chk("abort_run_b", 64'(b_out), 64'(O_RUN));
    chk("abort_cnt_b", 64'(ifb.stall_cnt), 64'd1);
    step();

    // mem_busy for 4 cycles after the first stall cycle of dut_b
    do_reset();
    set_lu_rs2();
    step();
    s_mr = 1'b0;
    s_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("hold%0d_b", i), 64'(b_out), 64'(O_FRZ));
      step();
    end
    s_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("resume%0d_b", i), 64'(b_out), 64'(O_STALL));
      step();
    end
    #1;
    chk("resume_run_b", 64'(b_out), 64'(O_RUN));
    chk("hold_cnt_b", 64'(ifb.hold_cnt), 64'd4);
    chk("hold_stall_b", 64'(ifb.stall_cnt), 64'd3);
    step();

    // Reset asserted while frozen in HOLD
    do_reset();
    s_busy = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_hold_a", 64'(a_out), 64'(O_RST));
    chk("rst_hold_b", 64'(b_out), 64'(O_RST));
    step();
    reset = 1'b0;
    s_busy = 1'b0;
    #1;
    chk("post_rst_a", 64'(a_out), 64'(O_RUN));
    chk("post_rst_hold_a", 64'(ifa.hold_cnt), 64'd0);
    chk("post_rst_hold_b", 64'(ifb.hold_cnt), 64'd0);
    step();

    // Randomized traffic; small register indices make hazards frequent, 3-bit counters saturate.
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 299) == 0);
      s_rs1  = 5'($urandom_range(0, 3));
      s_rs2  = 5'($urandom_range(0, 3));
      s_rt   = 5'($urandom_range(0, 3));
      s_u2   = 1'($urandom_range(0, 1));
      s_mr   = 1'($urandom_range(0, 1));
      s_br   = ($urandom_range(0, 9) < 3);
      s_zero = 1'($urandom_range(0, 1));
      s_busy = ($urandom_range(0, 99) < 15);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
